// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Purpose  : Two-slot VLIW operand-read block. Owns the architectural
//            register array, absorbs writebacks from two execution slots,
//            tracks in-flight destinations in a pending scoreboard, and
//            returns forwarding-resolved operands through a registered
//            valid/ready output stage. All state updates on the falling edge.
// Ports    : clk, reset        - clock (falling-edge active), async reset
//            req_*             - operand-read request from bundle decode
//            wb0_*, wb1_*      - writebacks from execution slots 0 and 1
//            op_valid/op_ready - output handshake, op_a/op_b operands
//            pending           - scoreboard bits, one per register
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_rd_en,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [NREG-1:0]   pending
);

  logic [DATA_W-1:0] r_array [NREG];
  logic [NREG-1:0]   r_pending;
  logic              r_opValid;
  logic [DATA_W-1:0] r_opA;
  logic [DATA_W-1:0] r_opB;

  // Per-source writeback matches; slot 1 takes precedence when both match.
  logic w_wb0Rs1, w_wb1Rs1, w_wb0Rs2, w_wb1Rs2, w_wb0Rd, w_wb1Rd;
  logic w_fwdRs1, w_fwdRs2, w_fwdRd;
  logic [DATA_W-1:0] w_valRs1, w_valRs2;
  logic w_slotFree, w_blockedRs1, w_blockedRs2, w_blockedRd, w_accept;

  assign w_wb0Rs1 = wb0_en && (wb0_addr == req_rs1);
  assign w_wb1Rs1 = wb1_en && (wb1_addr == req_rs1);
  assign w_wb0Rs2 = wb0_en && (wb0_addr == req_rs2);
  assign w_wb1Rs2 = wb1_en && (wb1_addr == req_rs2);
  assign w_wb0Rd  = wb0_en && (wb0_addr == req_rd);
  assign w_wb1Rd  = wb1_en && (wb1_addr == req_rd);

  assign w_fwdRs1 = w_wb0Rs1 || w_wb1Rs1;
  assign w_fwdRs2 = w_wb0Rs2 || w_wb1Rs2;
  assign w_fwdRd  = w_wb0Rd  || w_wb1Rd;

  assign w_valRs1 = w_wb1Rs1 ? wb1_data : (w_wb0Rs1 ? wb0_data : r_array[req_rs1]);
  assign w_valRs2 = w_wb1Rs2 ? wb1_data : (w_wb0Rs2 ? wb0_data : r_array[req_rs2]);

  // A pending register stops blocking in the very cycle its writeback
  // arrives, because the forwarded value is usable immediately.
  assign w_blockedRs1 = r_pending[req_rs1] && !w_fwdRs1;
  assign w_blockedRs2 = r_pending[req_rs2] && !w_fwdRs2;
  assign w_blockedRd  = req_rd_en && r_pending[req_rd] && !w_fwdRd;

  assign w_slotFree = !r_opValid || op_ready;
  assign req_ready  = !reset && w_slotFree && !w_blockedRs1 && !w_blockedRs2 && !w_blockedRd;
  assign w_accept   = req_valid && req_ready;

  // Register array: slot 1 is applied after slot 0 so it wins on a collision.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_array[i] <= '0;
      end
    end else begin
      if (wb0_en) r_array[wb0_addr] <= wb0_data;
      if (wb1_en) r_array[wb1_addr] <= wb1_data;
    end
  end

  // Scoreboard: a new destination mark beats a same-edge writeback clear,
  // so a WAW request accepted alongside the old writeback stays pending.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_accept && req_rd_en && (req_rd == ADDR_W'(i))) begin
          r_pending[i] <= 1'b1;
        end else if ((wb0_en && (wb0_addr == ADDR_W'(i))) ||
                     (wb1_en && (wb1_addr == ADDR_W'(i)))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage: operands hold while the consumer stalls.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_opValid <= 1'b0;
      r_opA     <= '0;
      r_opB     <= '0;
    end else if (w_accept) begin
      r_opValid <= 1'b1;
      r_opA     <= w_valRs1;
      r_opB     <= w_valRs2;
    end else if (op_ready) begin
      r_opValid <= 1'b0;
    end
  end

  assign op_valid = r_opValid;
  assign op_a     = r_opA;
  assign op_b     = r_opB;
  assign pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_port
// Purpose  : Scoreboard bench for regfile_read_port. Driver pushes expected
//            operand pairs on acceptance; a monitor compares the queue head
//            whenever op_valid is high and pops it on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_port;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b1;
  logic          reset;
  logic          req_valid, req_ready, req_rd_en;
  logic [AW-1:0] req_rs1, req_rs2, req_rd;
  logic          wb0_en, wb1_en;
  logic [AW-1:0] wb0_addr, wb1_addr;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic [NR-1:0] pending;

  int nVec  = 0;
  int nMiss = 0;
  logic [63:0] expQ[$];

  always #5 clk = ~clk;

  regfile_read_port #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_en(req_rd_en),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pending(pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: state changes on the falling edge, so the rising edge is a
  // quiet point where the upcoming handshake is already decided.
  always @(posedge clk) begin
    if (op_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        nVec++;
        nMiss++;
        $display("FAIL op_unexpected: got op_valid=1 expected no response outstanding");
      end else begin
        chk("op_a", op_a, expQ[0][63:32]);
        chk("op_b", op_b, expQ[0][31:0]);
        if (op_ready) void'(expQ.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic atPos();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rdEn,
                       input logic [31:0] ea, input logic [31:0] eb);
    bit done = 1'b0;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_rd_en = rdEn;
    req_valid = 1'b1;
    for (int k = 0; k < 8 && !done; k++) begin
      atPos();
      if (req_ready) begin
        expQ.push_back({ea, eb});
        done = 1'b1;
      end
      step();
    end
    req_valid = 1'b0;
    nVec++;
    if (!done) begin
      nMiss++;
      $display("FAIL issue_timeout: got req_ready=0 for 8 cycles expected acceptance");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_rd_en = 1'b0;
    wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
    op_ready = 1'b1;

    // Reset state
    step();
    chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_pending", {24'b0, pending}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    step();

    // Basic read through the array
    wb0_en = 1'b1; wb0_addr = 3'd3; wb0_data = 32'h12345678;
    step();
    wb0_en = 1'b0;
    issue(3'd3, 3'd0, 3'd0, 1'b0, 32'h12345678, 32'h0);
    chk("basic_op_valid", {31'b0, op_valid}, 32'd1);

    // RAW stall, then same-cycle forward from wb1
    issue(3'd1, 3'd1, 3'd5, 1'b1, 32'h0, 32'h0);
    chk("raw_pending_set", {24'b0, pending}, 32'h20);
    req_rs1 = 3'd5; req_rs2 = 3'd0; req_rd_en = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      atPos();
      chk("raw_stall_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    wb1_en = 1'b1; wb1_addr = 3'd5; wb1_data = 32'hDEADBEEF;
    atPos();
    chk("raw_unblock_ready", {31'b0, req_ready}, 32'd1);
    expQ.push_back({32'hDEADBEEF, 32'h0});
    step();
    req_valid = 1'b0; wb1_en = 1'b0;
    chk("raw_pending_clr", {24'b0, pending}, 32'h0);
    chk("raw_op_a", op_a, 32'hDEADBEEF);

    // Dual-write conflict: wb1 wins in both forwarding and the array
    wb0_en = 1'b1; wb0_addr = 3'd2; wb0_data = 32'h11;
    wb1_en = 1'b1; wb1_addr = 3'd2; wb1_data = 32'h22;
    issue(3'd3, 3'd2, 3'd0, 1'b0, 32'h12345678, 32'h22);
    wb0_en = 1'b0; wb1_en = 1'b0;
    issue(3'd2, 3'd2, 3'd0, 1'b0, 32'h22, 32'h22);
    step();

    // Backpressure: operands hold, waiting request accepted when op_ready rises
    op_ready = 1'b0;
    issue(3'd5, 3'd3, 3'd0, 1'b0, 32'hDEADBEEF, 32'h12345678);
    req_rs1 = 3'd2; req_rs2 = 3'd5; req_rd_en = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      atPos();
      chk("bp_op_valid", {31'b0, op_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    op_ready = 1'b1;
    atPos();
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    expQ.push_back({32'h22, 32'hDEADBEEF});
    step();
    req_valid = 1'b0;
    chk("bp_new_valid", {31'b0, op_valid}, 32'd1);
    chk("bp_new_a", op_a, 32'h22);

    // WAW: stall, then accepted alongside the writeback; set beats clear
    issue(3'd0, 3'd0, 3'd4, 1'b1, 32'h0, 32'h0);
    chk("waw_pending_set", {24'b0, pending}, 32'h10);
    req_rs1 = 3'd1; req_rs2 = 3'd1; req_rd = 3'd4; req_rd_en = 1'b1; req_valid = 1'b1;
    atPos();
    chk("waw_stall_ready", {31'b0, req_ready}, 32'd0);
    step();
    wb0_en = 1'b1; wb0_addr = 3'd4; wb0_data = 32'h44;
    atPos();
    chk("waw_unblock_ready", {31'b0, req_ready}, 32'd1);
    expQ.push_back({32'h0, 32'h0});
    step();
    req_valid = 1'b0; wb0_en = 1'b0;
    chk("waw_pending_kept", {24'b0, pending}, 32'h10);
    wb0_en = 1'b1; wb0_addr = 3'd4; wb0_data = 32'h45;
    step();
    wb0_en = 1'b0;
    chk("waw_pending_clr", {24'b0, pending}, 32'h0);

    // Async reset between edges with op_valid high and pending = 0x30
    issue(3'd4, 3'd2, 3'd4, 1'b1, 32'h45, 32'h22);
    issue(3'd3, 3'd3, 3'd5, 1'b1, 32'h12345678, 32'h12345678);
    op_ready = 1'b0;
    chk("ar_pending_pre", {24'b0, pending}, 32'h30);
    atPos();
    #1;
    reset = 1'b1;
    req_rs1 = 3'd0; req_rs2 = 3'd0; req_rd_en = 1'b0; req_valid = 1'b1;
    #1;
    chk("ar_op_valid", {31'b0, op_valid}, 32'd0);
    chk("ar_pending", {24'b0, pending}, 32'h0);
    chk("ar_op_a", op_a, 32'h0);
    chk("ar_op_b", op_b, 32'h0);
    chk("ar_req_ready", {31'b0, req_ready}, 32'd0);
    expQ.delete();
    step();
    reset = 1'b0; req_valid = 1'b0; op_ready = 1'b1;
    issue(3'd3, 3'd2, 3'd5, 1'b1, 32'h0, 32'h0);
    issue(3'd4, 3'd4, 3'd0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("drain_queue_empty", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
`default_nettype wire
